qspi_tran_shifter: RTL and testbench

Serial transfer engine directly downstream of the QSPI command FSM. Each active FSM phase state (READY, WREN, REQ, ADDR, RD_DUMMY, WR_CSR, WR_DATA, RD) makes the block shift the matching bits on the flash pins, or hold CS# high, then return a one-cycle `io_tran_finish` that advances the FSM. It generates SCK (SPI mode 0), CS#, and the DQ[3:0] drive/enable, and captures read data.

---
 rtl/qspi_tran_shifter_if.sv | 34 +++
 rtl/qspi_tran_shifter.sv | 203 ++++++++++++++++++++
 tb/tb_qspi_tran_shifter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_tran_shifter_if.sv
// Command-FSM side of the QSPI transfer engine: phase decodes, payloads and completion.
interface qspi_tran_shifter_if;
   logic        io_state_ready;
   logic        io_state_wren;
   logic        io_state_req;
   logic        io_state_addr;
   logic        io_state_rd_dummy;
   logic        io_state_wr_csr;
   logic        io_state_wr_data;
   logic        io_state_rd;
   logic        io_state_free;
   logic        io_state_finish;
   logic [7:0]  io_inst;
   logic [23:0] io_addr;
   logic [31:0] io_wr_data;
   logic        io_quad;
   logic        io_tran_finish;
   logic [31:0] io_rd_data;
   logic        io_rd_data_valid;

   modport master (
      output io_state_ready, io_state_wren, io_state_req, io_state_addr,
             io_state_rd_dummy, io_state_wr_csr, io_state_wr_data, io_state_rd,
             io_state_free, io_state_finish, io_inst, io_addr, io_wr_data, io_quad,
      input  io_tran_finish, io_rd_data, io_rd_data_valid
   );

   modport slave (
      input  io_state_ready, io_state_wren, io_state_req, io_state_addr,
             io_state_rd_dummy, io_state_wr_csr, io_state_wr_data, io_state_rd,
             io_state_free, io_state_finish, io_inst, io_addr, io_wr_data, io_quad,
      output io_tran_finish, io_rd_data, io_rd_data_valid
   );
endinterface

// File: rtl/qspi_tran_shifter.sv
// QSPI serial transfer engine: shifts one command-FSM phase onto the flash pins (SPI mode 0)
// and returns a one-cycle finish pulse; captures read words.
module qspi_tran_shifter #(
   parameter int unsigned CLK_DIV      = 2,
   parameter int unsigned DUMMY_CYCLES = 8,
   parameter int unsigned CS_GAP       = 4
) (
   input  logic                clock,
   input  logic                rst_n,
   qspi_tran_shifter_if.slave  bus,
   output logic                qspi_sck,
   output logic                qspi_cs_n,
   output logic [3:0]          qspi_dq_o,
   output logic [3:0]          qspi_dq_oe,
   input  logic [3:0]          qspi_dq_i
);

   localparam int unsigned SR_W      = 32;
   localparam int unsigned SHIFT_MAX = 2 * CLK_DIV * 32;
   localparam int unsigned CYC_MAX   = (SHIFT_MAX > CS_GAP) ? SHIFT_MAX : CS_GAP;
   localparam int unsigned REM_W     = $clog2(CYC_MAX + 1);
   localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;
   typedef enum logic [1:0] {K_OUT, K_READ, K_DUMMY} kind_e;

   state_e             state_q, state_d;
   kind_e              kind_q, kind_d;
   logic               quad_q, quad_d;
   logic [SR_W-1:0]    sr_q, sr_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               sck_q, sck_d;
   logic               cs_n_q, cs_n_d;
   logic [3:0]         dq_o_q, dq_o_d;
   logic [3:0]         dq_oe_q, dq_oe_d;
   logic               finish_q, finish_d;
   logic [SR_W-1:0]    rd_data_q, rd_data_d;
   logic               rd_valid_q, rd_valid_d;
   logic [REM_W-1:0]   n_ld;
   logic               shift_ld;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         kind_q     <= K_OUT;
         quad_q     <= 1'b0;
         sr_q       <= '0;
         rem_q      <= '0;
         div_q      <= '0;
         sck_q      <= 1'b0;
         cs_n_q     <= 1'b1;
         dq_o_q     <= '0;
         dq_oe_q    <= '0;
         finish_q   <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         quad_q     <= quad_d;
         sr_q       <= sr_d;
         rem_q      <= rem_d;
         div_q      <= div_d;
         sck_q      <= sck_d;
         cs_n_q     <= cs_n_d;
         dq_o_q     <= dq_o_d;
         dq_oe_q    <= dq_oe_d;
         finish_q   <= finish_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      quad_d     = quad_q;
      sr_d       = sr_q;
      rem_d      = rem_q;
      div_d      = div_q;
      sck_d      = sck_q;
      cs_n_d     = cs_n_q;
      dq_o_d     = '0;
      dq_oe_d    = '0;
      rd_data_d  = rd_data_q;
      n_ld       = '0;
      shift_ld   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            sck_d = 1'b0;
            div_d = '0;
            // Phase decode in fixed priority; illegal overlaps resolve to the first hit
            if (bus.io_state_ready) begin
               state_d = ST_GAP;
               rem_d   = REM_W'(CS_GAP - 1);
            end else if (bus.io_state_wren) begin
               shift_ld = 1'b1; kind_d = K_OUT; quad_d = 1'b0;
               sr_d     = {8'h06, 24'h0};
               n_ld     = REM_W'(8);
            end else if (bus.io_state_req) begin
               shift_ld = 1'b1; kind_d = K_OUT; quad_d = 1'b0;
               sr_d     = {bus.io_inst, 24'h0};
               n_ld     = REM_W'(8);
            end else if (bus.io_state_addr) begin
               shift_ld = 1'b1; kind_d = K_OUT; quad_d = bus.io_quad;
               sr_d     = {bus.io_addr, 8'h0};
               n_ld     = bus.io_quad ? REM_W'(6) : REM_W'(24);
            end else if (bus.io_state_rd_dummy) begin
               shift_ld = 1'b1; kind_d = K_DUMMY; quad_d = bus.io_quad;
               sr_d     = '0;
               n_ld     = REM_W'(DUMMY_CYCLES);
            end else if (bus.io_state_wr_csr) begin
               shift_ld = 1'b1; kind_d = K_OUT; quad_d = 1'b0;
               sr_d     = {bus.io_wr_data[7:0], 24'h0};
               n_ld     = REM_W'(8);
            end else if (bus.io_state_wr_data) begin
               shift_ld = 1'b1; kind_d = K_OUT; quad_d = bus.io_quad;
               sr_d     = bus.io_wr_data;
               n_ld     = bus.io_quad ? REM_W'(8) : REM_W'(32);
            end else if (bus.io_state_rd) begin
               shift_ld = 1'b1; kind_d = K_READ; quad_d = bus.io_quad;
               sr_d     = '0;
               n_ld     = bus.io_quad ? REM_W'(8) : REM_W'(32);
            end
            if (shift_ld) begin
               state_d = ST_SHIFT;
               rem_d   = REM_W'(2 * CLK_DIV) * n_ld - REM_W'(1);
            end
         end
         ST_SHIFT: begin
            // rem counts system cycles left; the final SCK fall coincides with returning to IDLE
            if (rem_q == '0) begin
               state_d = ST_IDLE;
               sck_d   = 1'b0;
               div_d   = '0;
            end else begin
               rem_d = rem_q - REM_W'(1);
               if (div_q == DIV_W'(CLK_DIV - 1)) begin
                  div_d = '0;
                  sck_d = ~sck_q;
                  if (!sck_q && kind_q == K_READ)
                     sr_d = quad_q ? {sr_q[SR_W-5:0], qspi_dq_i} : {sr_q[SR_W-2:0], qspi_dq_i[1]};
                  else if (sck_q && kind_q == K_OUT)
                     sr_d = quad_q ? (sr_q << 4) : (sr_q << 1);
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
         end
         ST_GAP: begin
            sck_d = 1'b0;
            if (rem_q == '0) state_d = ST_IDLE;
            else             rem_d   = rem_q - REM_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      // CS# drops only on opcode phases and releases on any end-of-transaction state
      if (bus.io_state_ready || bus.io_state_free || bus.io_state_finish || state_d == ST_GAP)
         cs_n_d = 1'b1;
      else if (state_q == ST_IDLE && (bus.io_state_wren || bus.io_state_req))
         cs_n_d = 1'b0;

      if (state_d == ST_SHIFT) begin
         case (kind_d)
            K_OUT: begin
               if (quad_d) begin
                  dq_oe_d = 4'b1111;
                  dq_o_d  = sr_d[SR_W-1 -: 4];
               end else begin
                  dq_oe_d = 4'b1101;
                  dq_o_d  = {3'b110, sr_d[SR_W-1]};
               end
            end
            K_READ: begin
               if (!quad_d) begin
                  dq_oe_d = 4'b1100;
                  dq_o_d  = 4'b1100;
               end
            end
            default: begin
               dq_oe_d = 4'b0000;
               dq_o_d  = 4'b0000;
            end
         endcase
      end

      finish_d   = (state_d != ST_IDLE) && (rem_d == '0);
      rd_valid_d = finish_d && (state_d == ST_SHIFT) && (kind_d == K_READ);
      if (rd_valid_d) rd_data_d = sr_d;
   end

   assign qspi_sck             = sck_q;
   assign qspi_cs_n            = cs_n_q;
   assign qspi_dq_o            = dq_o_q;
   assign qspi_dq_oe           = dq_oe_q;
   assign bus.io_tran_finish   = finish_q;
   assign bus.io_rd_data       = rd_data_q;
   assign bus.io_rd_data_valid = rd_valid_q;

endmodule

// File: tb/tb_qspi_tran_shifter.sv
// Directed scoreboard bench for qspi_tran_shifter with a quad-read flash model.
module tb_qspi_tran_shifter;
   localparam int unsigned CLK_DIV      = 2;
   localparam int unsigned DUMMY_CYCLES = 8;
   localparam int unsigned CS_GAP       = 4;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       sck, cs_n;
   logic [3:0] dq_o, dq_oe, dq_i;

   int errors = 0;
   int checks = 0;

   logic [7:0]  exp_pins[$];
   logic [31:0] exp_rd[$];

   int          fall_cnt = 0;
   int          rd_base  = 0;
   logic [31:0] rd_word  = 32'h0;

   always #5 clock = ~clock;

   qspi_tran_shifter_if bus ();

   qspi_tran_shifter #(
      .CLK_DIV      (CLK_DIV),
      .DUMMY_CYCLES (DUMMY_CYCLES),
      .CS_GAP       (CS_GAP)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .bus        (bus),
      .qspi_sck   (sck),
      .qspi_cs_n  (cs_n),
      .qspi_dq_o  (dq_o),
      .qspi_dq_oe (dq_oe),
      .qspi_dq_i  (dq_i)
   );

   // Flash presents the next nibble after every SCK falling edge, MSB first
   function automatic logic [3:0] flash_nib(input logic [31:0] w, input int idx);
      logic [31:0] t;
      if (idx < 0 || idx > 7) return 4'h0;
      t = w << (4 * idx);
      return t[31:28];
   endfunction

   always @(negedge sck) fall_cnt <= fall_cnt + 1;
   assign dq_i = flash_nib(rd_word, fall_cnt - rd_base);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_phase(input logic [7:0] v);
      bus.io_state_ready    = v[7];
      bus.io_state_wren     = v[6];
      bus.io_state_req      = v[5];
      bus.io_state_addr     = v[4];
      bus.io_state_rd_dummy = v[3];
      bus.io_state_wr_csr   = v[2];
      bus.io_state_wr_data  = v[1];
      bus.io_state_rd       = v[0];
   endtask

   task automatic push_single(input logic [31:0] data, input int n);
      for (int i = 0; i < n; i++) exp_pins.push_back({4'b1101, 3'b110, data[31-i]});
   endtask

   task automatic push_quad(input logic [31:0] data, input int n);
      logic [31:0] t;
      for (int i = 0; i < n; i++) begin
         t = data << (4 * i);
         exp_pins.push_back({4'b1111, t[31:28]});
      end
   endtask

   task automatic push_blank(input int n);
      for (int i = 0; i < n; i++) exp_pins.push_back(8'h00);
   endtask

   // Drive one phase from cycle T, check pins at each SCK rise, latency and CS# after load
   task automatic run_phase(input string tag, input logic [7:0] v, input int exp_lat,
                            input int exp_rises, input logic exp_cs);
      int          cyc = 0;
      int          rises = 0;
      bit          done = 1'b0;
      logic        prev_sck;
      logic [7:0]  e;
      logic [31:0] r;
      set_phase(v);
      prev_sck = sck;
      while (!done && cyc < 4000) begin
         @(posedge clock); #1;
         cyc++;
         if (cyc == 1) chk({tag, "_cs_after_load"}, 32'(cs_n), 32'(exp_cs));
         if (sck && !prev_sck) begin
            rises++;
            if (exp_pins.size() > 0) begin
               e = exp_pins.pop_front();
               chk({tag, "_pins"}, {24'h0, dq_oe, dq_o & dq_oe}, {24'h0, e});
            end
         end
         prev_sck = sck;
         if (bus.io_rd_data_valid) begin
            if (exp_rd.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL %s_rd_valid: observed=1 expected=0", tag);
            end else begin
               r = exp_rd.pop_front();
               chk({tag, "_rd_data"}, bus.io_rd_data, r);
               chk({tag, "_valid_with_finish"}, 32'(bus.io_tran_finish), 32'h1);
            end
         end
         if (bus.io_tran_finish) done = 1'b1;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      chk({tag, "_sck_pulses"}, 32'(rises), 32'(exp_rises));
      chk({tag, "_pins_left"}, 32'(exp_pins.size()), 32'h0);
      exp_pins.delete();
      set_phase(8'h00);
      @(posedge clock); #1;
   endtask

   initial begin
      int toggles;
      int fins;
      logic prev;

      rst_n = 1'b0;
      set_phase(8'h00);
      bus.io_state_free   = 1'b0;
      bus.io_state_finish = 1'b0;
      bus.io_inst         = 8'h00;
      bus.io_addr         = 24'h0;
      bus.io_wr_data      = 32'h0;
      bus.io_quad         = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_sck",      32'(sck),   32'h0);
      chk("rst_cs_n",     32'(cs_n),  32'h1);
      chk("rst_dq_o",     32'(dq_o),  32'h0);
      chk("rst_dq_oe",    32'(dq_oe), 32'h0);
      chk("rst_finish",   32'(bus.io_tran_finish),   32'h0);
      chk("rst_rd_data",  bus.io_rd_data,            32'h0);
      chk("rst_rd_valid", 32'(bus.io_rd_data_valid), 32'h0);
      @(negedge clock) rst_n = 1'b1;
      @(posedge clock); #1;

      run_phase("ready", 8'h80, CS_GAP, 0, 1'b1);

      bus.io_inst = 8'h03;
      push_single(32'h0300_0000, 8);
      run_phase("req", 8'h20, 2 * CLK_DIV * 8, 8, 1'b0);

      bus.io_addr = 24'h123456;
      bus.io_quad = 1'b1;
      push_quad(32'h1234_5600, 6);
      run_phase("addr_q", 8'h10, 2 * CLK_DIV * 6, 6, 1'b0);

      push_blank(DUMMY_CYCLES);
      run_phase("dummy", 8'h08, 2 * CLK_DIV * DUMMY_CYCLES, DUMMY_CYCLES, 1'b0);

      rd_word = 32'hDEAD_BEEF;
      rd_base = fall_cnt;
      push_blank(8);
      exp_rd.push_back(32'hDEAD_BEEF);
      run_phase("rd_q", 8'h01, 2 * CLK_DIV * 8, 8, 1'b0);
      chk("rd_hold_data",  bus.io_rd_data, 32'hDEAD_BEEF);
      chk("rd_hold_valid", 32'(bus.io_rd_data_valid), 32'h0);
      chk("rd_queue_left", 32'(exp_rd.size()), 32'h0);

      bus.io_quad = 1'b0;
      push_single(32'h0600_0000, 8);
      run_phase("wren", 8'h40, 2 * CLK_DIV * 8, 8, 1'b0);
      run_phase("ready2", 8'h80, CS_GAP, 0, 1'b1);

      bus.io_inst = 8'hA5;
      bus.io_addr = 24'hFFFFFF;
      push_single(32'hA500_0000, 8);
      run_phase("req_over_addr", 8'h30, 2 * CLK_DIV * 8, 8, 1'b0);

      bus.io_state_free = 1'b1;
      @(posedge clock); #1;
      bus.io_state_free = 1'b0;
      chk("free_cs_high", 32'(cs_n), 32'h1);

      // CHECK-type FSM states raise no phase input: engine must stay silent
      toggles = 0;
      fins    = 0;
      prev    = sck;
      repeat (100) begin
         @(posedge clock); #1;
         if (sck !== prev) toggles++;
         if (bus.io_tran_finish) fins++;
         prev = sck;
      end
      chk("idle_sck_toggles", 32'(toggles), 32'h0);
      chk("idle_finishes",    32'(fins),    32'h0);
      chk("idle_cs_n",        32'(cs_n),    32'h1);

      bus.io_inst = 8'h0B;
      push_single(32'h0B00_0000, 8);
      run_phase("req2", 8'h20, 2 * CLK_DIV * 8, 8, 1'b0);
      bus.io_addr = 24'hABCDEF;
      set_phase(8'h10);
      repeat (11) @(posedge clock);
      #1;
      chk("mid_addr_cs_low", 32'(cs_n), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("abort_cs_n",  32'(cs_n),  32'h1);
      chk("abort_sck",   32'(sck),   32'h0);
      chk("abort_dq_oe", 32'(dq_oe), 32'h0);
      set_phase(8'h00);
      @(posedge clock); #1;
      chk("abort_next_cs_n",   32'(cs_n), 32'h1);
      chk("abort_next_sck",    32'(sck),  32'h0);
      chk("abort_next_finish", 32'(bus.io_tran_finish), 32'h0);
      @(negedge clock) rst_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("post_abort_sck", 32'(sck), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
